// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM transmitter: a small sample FIFO feeds a first-order sigma-delta
// modulator that emits one bit per divided bit clock.
module pdm_audio_tx #(
    parameter int IN_FREQ    = 100_000_000,
    parameter int OUT_FREQ   = 3_072_000,
    parameter int OSR        = 64,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [DATA_W-1:0]           s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic                        pdm_clk,
    output logic                        pdm_out,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int CLK_DIVIDE = IN_FREQ / OUT_FREQ;
    localparam int DIV_W      = $clog2(CLK_DIVIDE);
    localparam int BIT_W      = $clog2(OSR);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIVIDE - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIVIDE / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DIV_W-1:0]  divCnt_q, divCnt_d;
    logic [BIT_W-1:0]  bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] curSample_q, curSample_d;
    logic              pdmClk_q, pdmClk_d;
    logic              pdmOut_q, pdmOut_d;
    logic              underrun_q, underrun_d;

    logic [DATA_W-1:0] fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;

    logic              bitTick, loadTick, push, pop;
    logic [DATA_W-1:0] offsetSample;
    logic [DATA_W:0]   sum;

    assign s_ready      = level_q < LVL_FULL;
    assign push         = s_valid && s_ready;
    assign bitTick      = en && (divCnt_q == DIV_LAST);
    assign loadTick     = bitTick && (bitCnt_q == BIT_LAST);
    assign pop          = loadTick && (level_q != '0);
    // Offset binary makes the carry-out density track the signed sample value.
    assign offsetSample = {~curSample_q[DATA_W-1], curSample_q[DATA_W-2:0]};
    assign sum          = {1'b0, acc_q} + {1'b0, offsetSample};

    always_comb begin
        divCnt_d    = divCnt_q;
        bitCnt_d    = bitCnt_q;
        acc_d       = acc_q;
        curSample_d = curSample_q;
        pdmOut_d    = pdmOut_q;
        underrun_d  = 1'b0;

        if (en) begin
            divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + 1'b1;
        end
        pdmClk_d = en && (divCnt_d >= DIV_HALF);

        if (!en) begin
            pdmOut_d = 1'b0;
        end else if (bitTick) begin
            acc_d    = sum[DATA_W-1:0];
            pdmOut_d = sum[DATA_W];
            bitCnt_d = (bitCnt_q == BIT_LAST) ? '0 : bitCnt_q + 1'b1;
        end

        // An empty FIFO at a load falls back to midscale rather than repeating.
        if (loadTick) begin
            curSample_d = pop ? fifoMem_q[rdPtr_q] : '0;
            underrun_d  = !pop;
        end
    end

    always_comb begin
        wrPtr_d = push ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divCnt_q    <= '0;
            bitCnt_q    <= BIT_LAST;
            acc_q       <= '0;
            curSample_q <= '0;
            pdmClk_q    <= 1'b0;
            pdmOut_q    <= 1'b0;
            underrun_q  <= 1'b0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
        end else begin
            divCnt_q    <= divCnt_d;
            bitCnt_q    <= bitCnt_d;
            acc_q       <= acc_d;
            curSample_q <= curSample_d;
            pdmClk_q    <= pdmClk_d;
            pdmOut_q    <= pdmOut_d;
            underrun_q  <= underrun_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= s_data;
        end
    end

    assign pdm_clk    = pdmClk_q;
    assign pdm_out    = pdmOut_q;
    assign underrun   = underrun_q;
    assign fifo_level = level_q;

endmodule

// File: doc/pdm_audio_tx.md
PDM_AUDIO_TX -- requirements
Module: pdm_audio_tx

Interface
REQ-001 Parameter IN_FREQ, 100_000_000, system clock frequency in Hz.
REQ-002 Parameter OUT_FREQ, 3_072_000, PDM bit rate in Hz; CLK_DIVIDE = IN_FREQ/OUT_FREQ (integer, 32 at defaults, even, >= 4).
REQ-003 Parameter OSR, 64, PDM bits per PCM sample.
REQ-004 Parameter DATA_W, 16, PCM sample width, signed two's complement.
REQ-005 Parameter FIFO_DEPTH, 4, sample buffer depth, power of two.
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 en  in  1  modulator enable; FIFO writes are accepted regardless of en.
REQ-009 s_data  in  DATA_W  PCM sample.
REQ-010 s_valid  in  1  s_data valid.
REQ-011 s_ready  out  1  FIFO can accept a sample.
REQ-012 pdm_clk  out  1  registered 50% duty bit clock to the DAC/filter.
REQ-013 pdm_out  out  1  registered PDM bit stream.
REQ-014 underrun  out  1  one-clk pulse when a sample load finds the FIFO empty.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Divider counter div_cnt SHALL count 0..CLK_DIVIDE-1 while en=1 and wrap to 0; bit_tick is asserted internally when div_cnt==CLK_DIVIDE-1 and en=1.
REQ-017 pdm_clk SHALL be registered, 1 while div_cnt >= CLK_DIVIDE/2, else 0; pdm_out changes only on the clk edge where div_cnt wraps (pdm_clk falling), so data is stable at pdm_clk rising.
REQ-018 Accumulator acc (DATA_W bits): on bit_tick, sum = acc + u, where u = cur_sample with MSB inverted (offset binary); acc <= sum[DATA_W-1:0]; pdm_out <= sum[DATA_W] (carry).
REQ-019 Bit counter bit_cnt SHALL count 0..OSR-1 on bit_tick; on bit_tick with bit_cnt==OSR-1, cur_sample SHALL be loaded from the FIFO head (FIFO popped) and used from the next bit_tick onward.
REQ-020 If the FIFO is empty at a load, cur_sample SHALL be set to 0 (midscale) and underrun SHALL pulse for exactly that clk.
REQ-021 Handshake: a sample is written when s_valid && s_ready; s_ready = (fifo_level < FIFO_DEPTH), derived from registered occupancy; s_data is ignored when the transfer does not occur.
REQ-022 Simultaneous write and pop in one clk SHALL leave fifo_level unchanged and preserve FIFO order; a write on the pop clk of a full FIFO is not accepted (s_ready already 0).
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH or underflows.
REQ-024 en=0: div_cnt, bit_cnt, acc, cur_sample hold; pdm_clk and pdm_out forced to 0 on the next clk; on en re-assertion the stream resumes from the held state.
REQ-025 Latency: a sample written into an empty FIFO appears at the next load, i.e. at most OSR*CLK_DIVIDE (2048 at defaults) clks later.

Reset
REQ-026 On rst: div_cnt=0, bit_cnt=OSR-1, acc=0, cur_sample=0, FIFO empty (fifo_level=0), pdm_clk=0, pdm_out=0, underrun=0, s_ready=1, all asynchronously.
REQ-027 rst asserted mid-stream SHALL discard buffered samples and accumulator state; first bit_tick after release occurs CLK_DIVIDE clks after release with en=1.

Verification
REQ-028 Reset: assert rst mid-stream -> all outputs/state per REQ-026 within the same cycle, s_ready=1, fifo_level=0.
REQ-029 Midscale: en=1, feed continuous 0x0000 -> pdm_out sequence 0,1,0,1,... per bit_tick; pdm_clk period 32 clks, 16 high/16 low.
REQ-030 Negative full scale: feed 0x8000 continuously -> after first load, pdm_out=0 for all 64 bits of each sample window; no underrun pulses.
REQ-031 FIFO full: en=0, s_valid=1 for 6 clks with 0x0001..0x0006 -> first four accepted, s_ready=0 after 4th, fifo_level=4; enable -> samples consumed in order 0x0001..0x0004 at 2048-clk intervals.
REQ-032 Underrun: FIFO empty at load tick -> underrun high exactly 1 clk, cur_sample=0, subsequent pdm_out alternates as midscale.
REQ-033 Simultaneous push/pop: fifo_level=2, write on the load clk -> fifo_level stays 2, order preserved; en toggled low for 100 clks -> pdm_clk/pdm_out 0, stream resumes with identical bit sequence.
